// File: rtl/flip_variable_selector.sv
// Picks the variable to flip from a selected unsatisfied clause: zero-break freebie first,
// then a noisy random walk, then greedy minimum break. The result is offered on a valid/ready pair.
module flip_variable_selector #(
    parameter int NSAT                  = 3,
    parameter int LITERAL_ADDRESS_WIDTH = 12,
    parameter int BREAK_WIDTH           = 8,
    parameter int RANDOM_NUM_WIDTH      = 18,
    parameter int NOISE_WIDTH           = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  clause_valid_i,
    input  logic [NSAT*LITERAL_ADDRESS_WIDTH-1:0] clause_i,
    input  logic [RANDOM_NUM_WIDTH-1:0]           random_i,
    input  logic [NOISE_WIDTH-1:0]                noise_i,
    output logic                                  ready_o,
    output logic                                  brk_rd_en_o,
    output logic [LITERAL_ADDRESS_WIDTH-2:0]      brk_rd_addr_o,
    input  logic [BREAK_WIDTH-1:0]                brk_rd_data_i,
    output logic                                  flip_valid_o,
    input  logic                                  flip_ready_i,
    output logic [LITERAL_ADDRESS_WIDTH-2:0]      flip_var_o,
    output logic [1:0]                            flip_mode_o,
    output logic                                  dropped_o,
    input  logic                                  clear_dropped_i
);

    localparam int LAW    = LITERAL_ADDRESS_WIDTH;
    localparam int IDX_W  = LITERAL_ADDRESS_WIDTH - 1;
    localparam int CNT_W  = $clog2(NSAT + 1);
    localparam int PICK_W = 8;

    typedef enum logic [1:0] {IDLE, FETCH, DECIDE, OUT} state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]            idx_q [NSAT];
    logic [BREAK_WIDTH-1:0]      brk_q [NSAT];
    logic [RANDOM_NUM_WIDTH-1:0] rand_q;
    logic [NOISE_WIDTH-1:0]      noise_q;
    logic [IDX_W-1:0]            var_q, var_d;
    logic [1:0]                  mode_q, mode_d;
    logic                        dropped_q, dropped_d;

    logic [NSAT-1:0]             lit_vld;
    logic [NSAT-1:0]             pol_unused;
    logic [CNT_W-1:0]            n_vld, pick, seen;
    logic                        noisy, free_hit, min_hit;
    logic [BREAK_WIDTH-1:0]      min_brk;
    logic [IDX_W-1:0]            dec_var;
    logic [1:0]                  dec_mode;

    // Shift-subtract remainder; n never exceeds NSAT so one subtract per bit suffices.
    function automatic logic [CNT_W-1:0] mod_n(input logic [PICK_W-1:0] v,
                                                input logic [CNT_W-1:0]  n);
        logic [CNT_W:0] r;
        r = '0;
        for (int i = PICK_W - 1; i >= 0; i--) begin
            r = {r[CNT_W-1:0], v[i]};
            if (r >= {1'b0, n}) r = r - {1'b0, n};
        end
        return r[CNT_W-1:0];
    endfunction

    always_comb begin
        for (int k = 0; k < NSAT; k++) begin
            lit_vld[k]    = |idx_q[k];
            pol_unused[k] = clause_i[k*LAW + IDX_W];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clause_valid_i) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                end
            end
            FETCH: begin
                // One extra cycle after the last read lets its data land in brk_q.
                if (cnt_q == CNT_W'(NSAT)) state_d = DECIDE;
                else                       cnt_d   = cnt_q + 1'b1;
            end
            DECIDE:  state_d = OUT;
            OUT:     if (flip_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        brk_rd_en_o   = 1'b0;
        brk_rd_addr_o = '0;
        for (int k = 0; k < NSAT; k++) begin
            if (state_q == FETCH && cnt_q == CNT_W'(k)) begin
                brk_rd_en_o   = 1'b1;
                brk_rd_addr_o = idx_q[k];
            end
        end
    end

    always_comb begin
        dec_var  = '0;
        dec_mode = 2'b11;
        n_vld    = '0;
        seen     = '0;
        free_hit = 1'b0;
        min_hit  = 1'b0;
        min_brk  = '0;
        for (int k = 0; k < NSAT; k++)
            if (lit_vld[k]) n_vld = n_vld + 1'b1;
        noisy = rand_q[NOISE_WIDTH-1:0] < noise_q;
        pick  = mod_n(rand_q[RANDOM_NUM_WIDTH-1 -: PICK_W], n_vld);
        for (int k = 0; k < NSAT; k++) begin
            if (lit_vld[k] && brk_q[k] == '0 && !free_hit) begin
                free_hit = 1'b1;
                dec_var  = idx_q[k];
                dec_mode = 2'b00;
            end
        end
        if (n_vld != '0 && !free_hit) begin
            if (noisy) begin
                for (int k = 0; k < NSAT; k++) begin
                    if (lit_vld[k]) begin
                        if (seen == pick) begin
                            dec_var  = idx_q[k];
                            dec_mode = 2'b01;
                        end
                        seen = seen + 1'b1;
                    end
                end
            end else begin
                for (int k = 0; k < NSAT; k++) begin
                    if (lit_vld[k] && (!min_hit || brk_q[k] < min_brk)) begin
                        min_hit  = 1'b1;
                        min_brk  = brk_q[k];
                        dec_var  = idx_q[k];
                        dec_mode = 2'b10;
                    end
                end
            end
        end
    end

    always_comb begin
        var_d     = (state_q == DECIDE) ? dec_var  : var_q;
        mode_d    = (state_q == DECIDE) ? dec_mode : mode_q;
        dropped_d = dropped_q;
        if (clear_dropped_i)                      dropped_d = 1'b0;
        if (clause_valid_i && state_q != IDLE)    dropped_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rand_q    <= '0;
            noise_q   <= '0;
            var_q     <= '0;
            mode_q    <= '0;
            dropped_q <= 1'b0;
            for (int k = 0; k < NSAT; k++) begin
                idx_q[k] <= '0;
                brk_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            var_q     <= var_d;
            mode_q    <= mode_d;
            dropped_q <= dropped_d;
            if (state_q == IDLE && clause_valid_i) begin
                for (int k = 0; k < NSAT; k++)
                    idx_q[k] <= clause_i[k*LAW +: IDX_W];
                rand_q  <= random_i;
                noise_q <= noise_i;
            end
            for (int k = 0; k < NSAT; k++)
                if (state_q == FETCH && cnt_q == CNT_W'(k + 1))
                    brk_q[k] <= brk_rd_data_i;
        end
    end

    assign ready_o      = (state_q == IDLE);
    assign flip_valid_o = (state_q == OUT);
    assign flip_var_o   = var_q;
    assign flip_mode_o  = mode_q;
    assign dropped_o    = dropped_q;

endmodule

// File: tb/tb_flip_variable_selector.sv
// Bench for flip_variable_selector: directed corner cases plus randomized clauses checked
// against a list-based reference of the freebie / random-walk / greedy selection rules.
module tb_flip_variable_selector;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clause_valid_i = 1'b0;
    logic [35:0] clause_i = '0;
    logic [17:0] random_i = '0;
    logic [7:0]  noise_i = '0;
    logic        ready_o;
    logic        brk_rd_en_o;
    logic [10:0] brk_rd_addr_o;
    logic [7:0]  brk_rd_data_i = '0;
    logic        flip_valid_o;
    logic        flip_ready_i = 1'b0;
    logic [10:0] flip_var_o;
    logic [1:0]  flip_mode_o;
    logic        dropped_o;
    logic        clear_dropped_i = 1'b0;

    logic [7:0]  brkmem [0:2047];
    int          n_chk = 0;
    int          n_fail = 0;

    flip_variable_selector dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clause_valid_i (clause_valid_i),
        .clause_i       (clause_i),
        .random_i       (random_i),
        .noise_i        (noise_i),
        .ready_o        (ready_o),
        .brk_rd_en_o    (brk_rd_en_o),
        .brk_rd_addr_o  (brk_rd_addr_o),
        .brk_rd_data_i  (brk_rd_data_i),
        .flip_valid_o   (flip_valid_o),
        .flip_ready_i   (flip_ready_i),
        .flip_var_o     (flip_var_o),
        .flip_mode_o    (flip_mode_o),
        .dropped_o      (dropped_o),
        .clear_dropped_i(clear_dropped_i)
    );

    always #5 clk_i = ~clk_i;

    // Break-count memory with one cycle of read latency.
    always @(posedge clk_i)
        if (brk_rd_en_o) brk_rd_data_i <= brkmem[brk_rd_addr_o];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: gather valid literals into a list, then apply the selection rules in order.
    task automatic model(input int v0, input int v1, input int v2, input int r, input int nz,
                         output int ev, output int em);
        int lv[$];
        int lb[$];
        int vs[3];
        int best;
        vs = '{v0, v1, v2};
        foreach (vs[k])
            if (vs[k] != 0) begin
                lv.push_back(vs[k]);
                lb.push_back(int'(brkmem[vs[k]]));
            end
        if (lv.size() == 0) begin
            ev = 0; em = 3; return;
        end
        foreach (lb[i])
            if (lb[i] == 0) begin
                ev = lv[i]; em = 0; return;
            end
        if ((r & 255) < nz) begin
            ev = lv[((r >> 10) & 255) % lv.size()]; em = 1; return;
        end
        best = 0;
        foreach (lb[i])
            if (lb[i] < lb[best]) best = i;
        ev = lv[best]; em = 2;
    endtask

    task automatic send(input int v0, input int v1, input int v2, input int pol,
                        input int r, input int nz);
        @(negedge clk_i);
        clause_i       = {pol[2], v2[10:0], pol[1], v1[10:0], pol[0], v0[10:0]};
        random_i       = r[17:0];
        noise_i        = nz[7:0];
        clause_valid_i = 1'b1;
        @(posedge clk_i);
        #1 clause_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk_i);
            #1 lat++;
            if (flip_valid_o) break;
        end
    endtask

    task automatic handshake(input string tag);
        flip_ready_i = 1'b1;
        @(posedge clk_i);
        #1 flip_ready_i = 1'b0;
        check_eq({tag, "_vld_low"}, 32'(flip_valid_o), 0);
        check_eq({tag, "_ready"}, 32'(ready_o), 1);
    endtask

    task automatic run_one(input string tag, input int v0, input int v1, input int v2,
                           input int pol, input int r, input int nz, input int stall);
        int ev, em, lat;
        model(v0, v1, v2, r, nz, ev, em);
        send(v0, v1, v2, pol, r, nz);
        wait_valid(lat);
        check_eq({tag, "_lat"}, lat, 5);
        check_eq({tag, "_var"}, 32'(flip_var_o), ev);
        check_eq({tag, "_mode"}, 32'(flip_mode_o), em);
        repeat (stall) @(posedge clk_i);
        #1 handshake(tag);
    endtask

    initial begin
        int ev, em, lat, seen;
        int v[3];
        foreach (brkmem[i]) brkmem[i] = 8'd0;

        // Reset values
        #12;
        check_eq("rst_ready", 32'(ready_o), 1);
        check_eq("rst_vld", 32'(flip_valid_o), 0);
        check_eq("rst_var", 32'(flip_var_o), 0);
        check_eq("rst_mode", 32'(flip_mode_o), 0);
        check_eq("rst_en", 32'(brk_rd_en_o), 0);
        check_eq("rst_addr", 32'(brk_rd_addr_o), 0);
        check_eq("rst_drop", 32'(dropped_o), 0);
        @(negedge clk_i) rst_ni = 1'b1;

        // Async reset mid-FETCH aborts the clause
        brkmem[5] = 3; brkmem[9] = 0; brkmem[17] = 0;
        send(5, 9, 17, 0, 0, 255);
        @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        check_eq("arst_ready", 32'(ready_o), 1);
        check_eq("arst_en", 32'(brk_rd_en_o), 0);
        check_eq("arst_addr", 32'(brk_rd_addr_o), 0);
        check_eq("arst_vld", 32'(flip_valid_o), 0);
        @(negedge clk_i) rst_ni = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk_i);
            #1 if (flip_valid_o) seen = 1;
        end
        check_eq("arst_noflip", seen, 0);

        // Freebie, greedy, random walk, empty and single-literal clauses
        run_one("free", 5, 9, 17, 3'b101, 0, 255, 0);
        brkmem[20] = 4; brkmem[21] = 2; brkmem[22] = 2;
        run_one("greedy", 20, 21, 22, 0, 0, 0, 0);
        brkmem[23] = 255; brkmem[24] = 254; brkmem[25] = 255;
        run_one("greedy_hi", 23, 24, 25, 3'b111, 0, 0, 1);
        brkmem[30] = 1; brkmem[31] = 2; brkmem[32] = 3;
        run_one("walk3", 30, 31, 32, 0, (7 << 10) | 8'h10, 8'h80, 0);
        run_one("walk2", 30, 0, 32, 0, (7 << 10) | 8'h10, 8'h80, 0);
        run_one("empty", 0, 0, 0, 3'b010, 0, 255, 0);
        brkmem[40] = 6;
        run_one("single", 0, 40, 0, 0, 0, 0, 2);

        // Stall, drop during stall, set-wins over clear
        send(20, 21, 22, 0, 0, 0);
        wait_valid(lat);
        check_eq("stall_lat", lat, 5);
        repeat (10) begin
            @(posedge clk_i);
            #1;
            check_eq("stall_vld", 32'(flip_valid_o), 1);
            check_eq("stall_var", 32'(flip_var_o), 21);
        end
        clause_valid_i = 1'b1;
        clause_i       = {1'b0, 11'd9, 1'b0, 11'd5, 1'b0, 11'd17};
        @(posedge clk_i);
        #1 clause_valid_i = 1'b0;
        check_eq("drop_set", 32'(dropped_o), 1);
        clause_valid_i  = 1'b1;
        clear_dropped_i = 1'b1;
        @(posedge clk_i);
        #1 clause_valid_i = 1'b0;
        clear_dropped_i = 1'b0;
        check_eq("drop_setwins", 32'(dropped_o), 1);
        check_eq("drop_var", 32'(flip_var_o), 21);
        check_eq("drop_mode", 32'(flip_mode_o), 2);
        handshake("drop_hs");
        seen = 0;
        repeat (8) begin
            @(posedge clk_i);
            #1 if (flip_valid_o || !ready_o) seen = 1;
        end
        check_eq("drop_ignored", seen, 0);
        clear_dropped_i = 1'b1;
        @(posedge clk_i);
        #1 clear_dropped_i = 1'b0;
        check_eq("drop_clear", 32'(dropped_o), 0);

        // Randomized clauses against the reference
        for (int it = 0; it < 60; it++) begin
            foreach (v[k]) begin
                v[k] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 2047));
                if (v[k] != 0) brkmem[v[k]] = 8'($urandom_range(0, 9));
            end
            run_one("rand", v[0], v[1], v[2], int'($urandom_range(0, 7)),
                    int'($urandom & 32'h3FFFF), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
